// File: rtl/pipe_add_prot.sv
// Parity-protected cascaded adder pipeline with per-stage hold, valid tracking,
// sticky alarm and a soft-error injection port. Optional alarm counter: PIPE_ADD_PROT_ERR_CNT_EN.
module pipe_add_prot #(
   parameter int WIDTH   = 8,
   parameter int LAYERS  = 2,
   parameter int STAGE_W = 1,
   parameter int BIT_W   = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   input  logic               in_valid,
   input  logic [LAYERS-1:0]  hold,
   output logic [WIDTH-1:0]   sum,
   output logic [WIDTH-1:0]   out_b,
   output logic               out_valid,
   output logic [LAYERS-1:0]  err_stage,
   output logic               alarm,
   output logic               alarm_sticky,
   input  logic               alarm_clr,
   input  logic               inj_en,
   input  logic [STAGE_W-1:0] inj_stage,
   input  logic [BIT_W-1:0]   inj_bit,
   output logic [7:0]         err_count
);

   logic [WIDTH-1:0]   s_q     [LAYERS];
   logic [WIDTH-1:0]   b_q     [LAYERS];
   logic [WIDTH-1:0]   src_a   [LAYERS];
   logic [WIDTH-1:0]   src_b   [LAYERS];
   logic [WIDTH-1:0]   clean_s [LAYERS];
   logic [WIDTH-1:0]   clean_b [LAYERS];
   logic [WIDTH-1:0]   nxt_s   [LAYERS];
   logic [WIDTH-1:0]   nxt_b   [LAYERS];
   logic [2*WIDTH-1:0] inj_mask [LAYERS];
   logic [LAYERS-1:0]  v_q, ps_q, pb_q;
   logic [LAYERS-1:0]  src_v, nxt_v, nxt_ps, nxt_pb;
   logic [LAYERS-1:0]  consume;

   always_comb begin
      src_a[0] = in_a;
      src_b[0] = in_b;
      src_v[0] = in_valid;
      for (int k = 1; k < LAYERS; k++) begin
         src_a[k] = s_q[k-1];
         src_b[k] = b_q[k-1];
         src_v[k] = v_q[k-1];
      end
   end

   // Parity always covers the clean value; the injected flip lands only on the data.
   always_comb begin
      for (int k = 0; k < LAYERS; k++) begin
         inj_mask[k] = '0;
         if (inj_en && (inj_stage == STAGE_W'(k)))
            inj_mask[k] = {{(2*WIDTH-1){1'b0}}, 1'b1} << inj_bit;
         clean_s[k]   = hold[k] ? s_q[k] : src_a[k] + src_b[k];
         clean_b[k]   = hold[k] ? b_q[k] : src_b[k];
         nxt_ps[k]    = hold[k] ? ps_q[k] : ^clean_s[k];
         nxt_pb[k]    = hold[k] ? pb_q[k] : ^clean_b[k];
         nxt_v[k]     = hold[k] ? v_q[k]  : src_v[k];
         nxt_s[k]     = clean_s[k] ^ inj_mask[k][WIDTH-1:0];
         nxt_b[k]     = clean_b[k] ^ inj_mask[k][2*WIDTH-1:WIDTH];
         err_stage[k] = (^s_q[k] ^ ps_q[k]) | (^b_q[k] ^ pb_q[k]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < LAYERS; k++) begin
            s_q[k] <= '0;
            b_q[k] <= '0;
         end
         v_q  <= '0;
         ps_q <= '0;
         pb_q <= '0;
      end else begin
         for (int k = 0; k < LAYERS; k++) begin
            s_q[k] <= nxt_s[k];
            b_q[k] <= nxt_b[k];
         end
         v_q  <= nxt_v;
         ps_q <= nxt_ps;
         pb_q <= nxt_pb;
      end
   end

   // A stage only counts as consumed when its successor is loading; the last stage always is.
   assign consume = ~(hold >> 1);
   assign alarm   = |(err_stage & consume);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         alarm_sticky <= 1'b0;
      else if (alarm)
         alarm_sticky <= 1'b1;
      else if (alarm_clr)
         alarm_sticky <= 1'b0;
   end

`ifdef PIPE_ADD_PROT_ERR_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err_count <= 8'd0;
      else if (alarm_clr)
         err_count <= alarm ? 8'd1 : 8'd0;
      else if (alarm && (err_count != 8'hFF))
         err_count <= err_count + 8'd1;
   end
`else
   assign err_count = 8'd0;
`endif

   assign sum       = s_q[LAYERS-1];
   assign out_b     = b_q[LAYERS-1];
   assign out_valid = v_q[LAYERS-1];

endmodule

// File: tb/tb_pipe_add_prot.sv
// Scoreboard bench for pipe_add_prot (WIDTH=8, LAYERS=2): directed vectors, injection,
// hold and mid-flight reset. Counter expectations follow PIPE_ADD_PROT_ERR_CNT_EN.
module tb_pipe_add_prot;
   localparam int WIDTH   = 8;
   localparam int LAYERS  = 2;
   localparam int STAGE_W = 1;
   localparam int BIT_W   = 4;
`ifdef PIPE_ADD_PROT_ERR_CNT_EN
   localparam logic [31:0] CNT_MASK = 32'hFFFF_FFFF;
`else
   localparam logic [31:0] CNT_MASK = 32'h0;
`endif

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [WIDTH-1:0]   in_a = '0, in_b = '0;
   logic               in_valid = 1'b0;
   logic [LAYERS-1:0]  hold = '0;
   logic [WIDTH-1:0]   sum, out_b;
   logic               out_valid;
   logic [LAYERS-1:0]  err_stage;
   logic               alarm, alarm_sticky;
   logic               alarm_clr = 1'b0;
   logic               inj_en = 1'b0;
   logic [STAGE_W-1:0] inj_stage = '0;
   logic [BIT_W-1:0]   inj_bit = '0;
   logic [7:0]         err_count;

   int errors = 0;
   int checks = 0;
   logic [2*WIDTH-1:0] sb_q [$];

   pipe_add_prot #(.WIDTH(WIDTH), .LAYERS(LAYERS), .STAGE_W(STAGE_W), .BIT_W(BIT_W)) dut (
      .clk(clk), .rst_n(rst_n), .in_a(in_a), .in_b(in_b), .in_valid(in_valid), .hold(hold),
      .sum(sum), .out_b(out_b), .out_valid(out_valid), .err_stage(err_stage), .alarm(alarm),
      .alarm_sticky(alarm_sticky), .alarm_clr(alarm_clr), .inj_en(inj_en),
      .inj_stage(inj_stage), .inj_bit(inj_bit), .err_count(err_count)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   // Drives one cycle of inputs, queues the hand-computed result for valid beats, then steps one edge.
   task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic v,
                                input logic [WIDTH-1:0] exp_sum, input logic [LAYERS-1:0] h,
                                input logic ie, input logic [STAGE_W-1:0] istg,
                                input logic [BIT_W-1:0] ibit, input logic clr);
      in_a = a; in_b = b; in_valid = v; hold = h;
      inj_en = ie; inj_stage = istg; inj_bit = ibit; alarm_clr = clr;
      if (v) sb_q.push_back({b, exp_sum});
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic [LAYERS-1:0] h, input logic clr);
      applyStimulus(8'h00, 8'h00, 1'b0, 8'h00, h, 1'b0, 1'b0, 4'd0, clr);
   endtask

   initial begin
      logic [2*WIDTH-1:0] exp_item;
      forever begin
         @(negedge clk);
         if (rst_n && out_valid) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_valid: got sum=0x%0h expected no output", sum);
            end else begin
               exp_item = sb_q.pop_front();
               checkOutput("sum", 32'(sum), 32'(exp_item[WIDTH-1:0]));
               checkOutput("out_b", 32'(out_b), 32'(exp_item[2*WIDTH-1:WIDTH]));
            end
         end
      end
   end

   initial begin
      #12;
      checkOutput("rst_sum", 32'(sum), 32'h0);
      checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
      checkOutput("rst_err_stage", 32'(err_stage), 32'h0);
      checkOutput("rst_sticky", 32'(alarm_sticky), 32'h0);
      checkOutput("rst_err_count", 32'(err_count), 32'h0);
      rst_n = 1'b1;

      $display("[TB] basic add");
      applyStimulus(8'h10, 8'h03, 1'b1, 8'h16, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         idle(2'b00, 1'b0);
         checkOutput("t1_err_stage", 32'(err_stage), 32'h0);
         checkOutput("t1_alarm", 32'(alarm), 32'h0);
      end

      $display("[TB] wrap-around vectors");
      applyStimulus(8'hF0, 8'h10, 1'b1, 8'h10, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0);
      applyStimulus(8'hFF, 8'hFF, 1'b1, 8'hFD, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0);
      applyStimulus(8'h25, 8'h40, 1'b1, 8'hA5, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0);
      for (int i = 0; i < 3; i++) idle(2'b00, 1'b0);

      $display("[TB] inject stage 1 sum bit 0");
      applyStimulus(8'h00, 8'h00, 1'b0, 8'h00, 2'b00, 1'b1, 1'b1, 4'd0, 1'b0);
      checkOutput("t3_err_stage", 32'(err_stage), 32'h2);
      checkOutput("t3_alarm", 32'(alarm), 32'h1);
      checkOutput("t3_sticky_pre", 32'(alarm_sticky), 32'h0);
      idle(2'b00, 1'b0);
      checkOutput("t3_err_clean", 32'(err_stage), 32'h0);
      checkOutput("t3_sticky", 32'(alarm_sticky), 32'h1);
      checkOutput("t3_err_count", 32'(err_count), 32'h1 & CNT_MASK);
      idle(2'b00, 1'b1);
      checkOutput("t3_clr_sticky", 32'(alarm_sticky), 32'h0);
      checkOutput("t3_clr_count", 32'(err_count), 32'h0);

      $display("[TB] inject stage 0 B bit 1 behind held successor");
      applyStimulus(8'h00, 8'h00, 1'b0, 8'h00, 2'b10, 1'b1, 1'b0, 4'd9, 1'b0);
      checkOutput("t4_err_stage", 32'(err_stage), 32'h1);
      checkOutput("t4_alarm_held", 32'(alarm), 32'h0);
      checkOutput("t4_sticky_held", 32'(alarm_sticky), 32'h0);
      hold = 2'b00;
      inj_en = 1'b0;
      #1;
      checkOutput("t4_alarm_released", 32'(alarm), 32'h1);
      idle(2'b00, 1'b0);
      checkOutput("t4_err_reload", 32'(err_stage), 32'h0);
      checkOutput("t4_sticky", 32'(alarm_sticky), 32'h1);
      checkOutput("t4_err_count", 32'(err_count), 32'h1 & CNT_MASK);
      checkOutput("t4_sum_corrupt_b", 32'(sum), 32'h2);
      checkOutput("t4_out_b_corrupt_b", 32'(out_b), 32'h2);
      idle(2'b00, 1'b1);
      checkOutput("t4_clr_sticky", 32'(alarm_sticky), 32'h0);

      $display("[TB] clear versus alarm priority");
      applyStimulus(8'h00, 8'h00, 1'b0, 8'h00, 2'b00, 1'b1, 1'b1, 4'd0, 1'b0);
      checkOutput("t5_alarm", 32'(alarm), 32'h1);
      idle(2'b00, 1'b1);
      checkOutput("t5_set_wins", 32'(alarm_sticky), 32'h1);
      checkOutput("t5_count_load1", 32'(err_count), 32'h1 & CNT_MASK);
      idle(2'b00, 1'b1);
      checkOutput("t5_cleared", 32'(alarm_sticky), 32'h0);
      checkOutput("t5_count_cleared", 32'(err_count), 32'h0);

      $display("[TB] stage 0 hold");
      applyStimulus(8'h05, 8'h02, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0);
      applyStimulus(8'h33, 8'h44, 1'b0, 8'h00, 2'b01, 1'b0, 1'b0, 4'd0, 1'b0);
      checkOutput("t6_hold_sum0", 32'(sum), 32'h09);
      applyStimulus(8'h71, 8'h0E, 1'b0, 8'h00, 2'b01, 1'b0, 1'b0, 4'd0, 1'b0);
      checkOutput("t6_hold_sum1", 32'(sum), 32'h09);
      applyStimulus(8'hC8, 8'h5A, 1'b0, 8'h00, 2'b01, 1'b0, 1'b0, 4'd0, 1'b0);
      checkOutput("t6_hold_sum2", 32'(sum), 32'h09);
      checkOutput("t6_hold_out_b", 32'(out_b), 32'h02);

      $display("[TB] mid-flight reset");
      applyStimulus(8'h00, 8'h00, 1'b0, 8'h00, 2'b00, 1'b1, 1'b1, 4'd3, 1'b0);
      inj_en = 1'b0;
      in_a = 8'h40; in_b = 8'h04; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0; in_a = 8'h00; in_b = 8'h00;
      checkOutput("t6_sticky_pre_rst", 32'(alarm_sticky), 32'h1);
      checkOutput("t6_out_valid_pre_rst", 32'(out_valid), 32'h0);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("t6_rst_sum", 32'(sum), 32'h0);
      checkOutput("t6_rst_out_b", 32'(out_b), 32'h0);
      checkOutput("t6_rst_out_valid", 32'(out_valid), 32'h0);
      checkOutput("t6_rst_err_stage", 32'(err_stage), 32'h0);
      checkOutput("t6_rst_alarm", 32'(alarm), 32'h0);
      checkOutput("t6_rst_sticky", 32'(alarm_sticky), 32'h0);
      checkOutput("t6_rst_count", 32'(err_count), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(2'b00, 1'b0);
      checkOutput("t6_post_rst_valid", 32'(out_valid), 32'h0);
      checkOutput("t6_post_rst_sum", 32'(sum), 32'h0);
      idle(2'b00, 1'b0);

      checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipe_add_prot.md
Name: pipe_add_prot

Overview:
Parametrised, parity-protected cascaded adder pipeline of LAYERS stages, each WIDTH bits wide.
- Each stage adds the running sum and the forwarded operand B, then registers both with separate parity bits.
- Per-stage hold, a valid bit, a registered sticky alarm, and a fault-injection port for soft-error campaigns.
- Successor to the fixed 8-bit/2-layer protected adder: generic width/depth, separate operands, reset, valid tracking, injection.

Parameters:
WIDTH, 8, data width of operands, stage registers and result
LAYERS, 2, number of adder stages (>=1)
STAGE_W, 1, width of inj_stage; must satisfy 2**STAGE_W >= LAYERS
BIT_W, 4, width of inj_bit; must satisfy 2**BIT_W >= 2*WIDTH

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
in_a  input  WIDTH  initial sum operand
in_b  input  WIDTH  addend, forwarded through every stage
in_valid  input  1  in_a/in_b qualifier
hold  input  LAYERS  hold[k]=1 freezes stage k
sum  output  WIDTH  stage LAYERS-1 sum register
out_b  output  WIDTH  stage LAYERS-1 forwarded B register
out_valid  output  1  stage LAYERS-1 valid bit
err_stage  output  LAYERS  per-stage parity mismatch, combinational
alarm  output  1  filtered error, combinational
alarm_sticky  output  1  registered latched alarm
alarm_clr  input  1  clears alarm_sticky (and err_count)
inj_en  input  1  fault-injection strobe
inj_stage  input  STAGE_W  target stage
inj_bit  input  BIT_W  bit < WIDTH selects a sum bit; WIDTH..2*WIDTH-1 selects B bit (inj_bit-WIDTH)
err_count  output  8  alarm-cycle counter (optional feature)

Behaviour:
- Stage k registers: s_k, b_k (WIDTH), v_k, ps_k, pb_k. Sources: stage 0 uses in_a/in_b/in_valid; stage k>0 uses s_{k-1}/b_{k-1}/v_{k-1}.
- Load when hold[k]=0:
  - s_k <= src_a + src_b, mod 2^WIDTH, carry dropped.
  - b_k <= src_b; v_k <= src_v.
  - ps_k <= XOR-reduce of the new s_k; pb_k <= XOR-reduce of the new b_k.
- Hold when hold[k]=1: all stage-k registers retain. Stages hold independently; no backpressure propagation.
- Result: with no holds, inputs at edge t appear on sum/out_b/out_valid after edge t+LAYERS-1 (LAYERS-cycle latency). sum = in_a + LAYERS*in_b mod 2^WIDTH; out_b = in_b.
- Injection: when inj_en=1 and inj_stage=k<LAYERS, the selected bit of the value written at this edge (new or retained) is inverted. Parity is computed from the uncorrupted value. inj_stage>=LAYERS or inj_bit>=2*WIDTH: no effect.
- err_stage[k] = (^s_k ^ ps_k) | (^b_k ^ pb_k). Not gated by v_k.
- alarm = OR over k of err_stage[k] & ~hold[k+1]; for k=LAYERS-1 the term is err_stage[k] alone.
  - A corrupt stage whose successor is frozen is not yet consumed, so it is not flagged.
- alarm_sticky:
  - Set at the edge where alarm=1.
  - Cleared at the edge where alarm_clr=1 and alarm=0.
  - Set wins when both are asserted.
- Reset (any time, including mid-flight): all s/b/v/parity registers, alarm_sticky and err_count go to 0 immediately. err_stage=0, alarm=0, sum=0, out_b=0, out_valid=0.

Optional Feature:
PIPE_ADD_PROT_ERR_CNT_EN
- Defined: err_count increments at every edge with alarm=1 and saturates at 255. alarm_clr=1 with alarm=0 clears it; alarm_clr=1 with alarm=1 loads 1.
- Undefined: counter logic absent; err_count tied to 0.

Test Plan:
1. WIDTH=8, LAYERS=2, reset, then in_a=0x10, in_b=0x03, in_valid=1 for one cycle, hold=0 -> two edges later sum=0x16, out_b=0x03, out_valid=1; err_stage=0, alarm=0 throughout.
2. Wrap: in_a=0xF0, in_b=0x10 -> sum=0x10 after 2 cycles. in_a=0xFF, in_b=0xFF -> sum=0xFD.
3. inj_en=1, inj_stage=1, inj_bit=0 for one edge -> err_stage=2'b10 and alarm=1. Next edge: alarm_sticky=1, err_count=1 (macro defined) or 0 (undefined).
4. hold[1]=1, inject inj_stage=0, inj_bit=9 -> err_stage[0]=1, alarm=0, sticky stays 0.
   - Drop hold[1] -> alarm=1 that cycle.
   - Next edge: err_stage[1]=0, since parity is recomputed on the load, and alarm_sticky=1.
5. alarm_clr=1 in the same cycle as alarm=1 -> alarm_sticky remains 1. alarm_clr=1 with alarm=0 -> alarm_sticky=0 and err_count=0 at that edge.
6. Hold hold[0]=1 for 3 cycles with changing inputs -> stage 0 retains its value and downstream sum is unchanged. Assert rst_n=0 mid-flight -> all outputs 0 without a clock edge.
